// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared encodings, defaults and rcon table for the AES-128 round sequencer
package aes_pkg;

  localparam int NR_DEFAULT = 10;
  localparam int RW_DEFAULT = 4;

  typedef enum logic [1:0] {
    SEL_WHITEN = 2'd0,
    SEL_ROUND  = 2'd1,
    SEL_FINAL  = 2'd2,
    SEL_RSVD   = 2'd3
  } dp_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index 0 and anything past the last AES-128 round map to zero.
  function automatic logic [7:0] rcon_of(input int unsigned idx);
    case (idx)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// rtl/aes_round_ctrl_if.sv - block, key and result handshakes plus datapath controls
interface aes_round_ctrl_if import aes_pkg::*; #(parameter int RW = RW_DEFAULT) ();

  logic          in_valid;
  logic          in_ready;
  logic          key_req;
  logic          key_ack;
  logic [RW-1:0] key_round;
  logic [7:0]    rcon;
  logic          dp_load;
  logic [1:0]    dp_sel;
  logic          dp_en;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  modport master (
    input  in_valid, key_ack, out_ready,
    output in_ready, key_req, key_round, rcon, dp_load, dp_sel, dp_en, out_valid, busy
  );

  modport slave (
    output in_valid, key_ack, out_ready,
    input  in_ready, key_req, key_round, rcon, dp_load, dp_sel, dp_en, out_valid, busy
  );

endinterface

// File: rtl/aes_rcon.sv
// rtl/aes_rcon.sv - combinational round index to round constant lookup
module aes_rcon import aes_pkg::*; #(
  parameter int RW = RW_DEFAULT
) (
  input  logic [RW-1:0] round,
  output logic [7:0]    rcon
);

  always_comb begin
    rcon = rcon_of(32'(round));
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// rtl/aes_round_ctrl.sv - iterative AES-128 round sequencer: whitening, NR-1 rounds, final round
module aes_round_ctrl import aes_pkg::*; #(
  parameter int NR = NR_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_round_ctrl_if.master  bus
);

  state_t        state;
  logic [RW-1:0] round_q;
  logic          in_ready_q;
  logic          key_req_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          accept;
  logic          apply;
  dp_sel_t       sel;
  logic [7:0]    rcon;

  assign accept = in_ready_q & bus.in_valid;
  assign apply  = key_req_q & bus.key_ack;

  always_comb begin
    sel = SEL_ROUND;
    if (round_q == '0) begin
      sel = SEL_WHITEN;
    end else if (round_q == RW'(NR)) begin
      sel = SEL_FINAL;
    end
  end

  // Outputs other than load/enable/select are registered so the datapath sees clean Moore controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      round_q     <= '0;
      in_ready_q  <= 1'b1;
      key_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_KEY;
            round_q    <= '0;
            in_ready_q <= 1'b0;
            key_req_q  <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_KEY: begin
          if (bus.key_ack) begin
            if (round_q == RW'(NR)) begin
              state       <= ST_DONE;
              key_req_q   <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              round_q <= round_q + RW'(1);
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          round_q     <= '0;
          in_ready_q  <= 1'b1;
          key_req_q   <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  aes_rcon #(.RW(RW)) u_rcon (
    .round (round_q),
    .rcon  (rcon)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.key_req   = key_req_q;
  assign bus.key_round = round_q;
  assign bus.rcon      = rcon;
  assign bus.dp_load   = accept;
  assign bus.dp_en     = apply;
  assign bus.dp_sel    = apply ? sel : SEL_WHITEN;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb/tb_aes_round_ctrl.sv - bench for aes_round_ctrl with protocol model and AES datapath model
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam int RW = 4;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_round_ctrl_if #(.RW(RW)) bus();

  aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // ---------------- key source ----------------
  int ack_mode = 0;
  int kcnt = 0;
  initial bus.key_ack = 1'b0;

  always @(posedge clk) begin
    #1;
    if (bus.key_req) kcnt++; else kcnt = 0;
    case (ack_mode)
      1:       bus.key_ack = bus.key_req;
      2:       bus.key_ack = bus.key_req && (kcnt % 3 == 0);
      3:       bus.key_ack = 1'b1;
      default: bus.key_ack = 1'b0;
    endcase
  end

  // ---------------- datapath model driven by the DUT controls ----------------
  logic [127:0] dp_state = '0;
  logic [127:0] rk_prev = '0;
  logic [127:0] rk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dp_load) dp_state = PT;
      if (bus.dp_en) begin
        rk = (bus.key_round == 0) ? KEY : key_step(rk_prev, bus.rcon);
        rk_prev = rk;
        case (bus.dp_sel)
          2'd0:    dp_state = dp_state ^ rk;
          2'd1:    dp_state = mix_columns(shift_rows(sub_bytes(dp_state))) ^ rk;
          2'd2:    dp_state = shift_rows(sub_bytes(dp_state)) ^ rk;
          default: dp_state = 'x;
        endcase
      end
    end
  end

  // ---------------- protocol model + per-cycle compare ----------------
  int rcon_tab [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  bit m_busy = 1'b0;
  int m_acks = 0;
  int m_last_kr = 0;

  always @(negedge clk) begin
    bit e_req, e_ov, e_load, e_en;
    int e_kr, e_sel;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_acks = 0;
      m_last_kr = 0;
    end
    e_req  = m_busy && (m_acks <= NR);
    e_ov   = m_busy && (m_acks > NR);
    e_kr   = m_busy ? ((m_acks > NR) ? NR : m_acks) : m_last_kr;
    e_load = !m_busy && bus.in_valid;
    e_en   = e_req && bus.key_ack;
    e_sel  = !e_en ? 0 : (m_acks == 0) ? 0 : (m_acks == NR) ? 2 : 1;
    check("in_ready",  bus.in_ready,  !m_busy);
    check("busy",      bus.busy,      m_busy);
    check("key_req",   bus.key_req,   e_req);
    check("out_valid", bus.out_valid, e_ov);
    check("key_round", bus.key_round, e_kr);
    check("rcon",      bus.rcon,      rcon_tab[e_kr]);
    check("dp_load",   bus.dp_load,   e_load);
    check("dp_en",     bus.dp_en,     e_en);
    check("dp_sel",    bus.dp_sel,    e_sel);
    if (rst_n) begin
      if (e_load) begin
        m_busy = 1'b1;
        m_acks = 0;
      end else if (e_en) begin
        m_acks++;
        if (m_acks > NR) m_last_kr = NR;
      end else if (e_ov && bus.out_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- event recorder ----------------
  int tcyc = 0;
  int load_q[$], en_q[$], sel_q[$], kr_q[$], rcon_q[$], hs_q[$];
  logic [127:0] ct_q[$];
  int ov_first = -1;
  int en_noack = 0;
  int ack_noen = 0;

  always @(negedge clk) begin
    if (bus.dp_load) load_q.push_back(tcyc);
    if (bus.dp_en) begin
      en_q.push_back(tcyc);
      sel_q.push_back(int'(bus.dp_sel));
      kr_q.push_back(int'(bus.key_round));
      rcon_q.push_back(int'(bus.rcon));
      if (!bus.key_ack) en_noack++;
    end
    if (bus.key_req && bus.key_ack && !bus.dp_en) ack_noen++;
    if (bus.out_valid && ov_first < 0) ov_first = tcyc;
    if (bus.out_valid && bus.out_ready) begin
      hs_q.push_back(tcyc);
      ct_q.push_back(dp_state);
    end
    tcyc++;
  end

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_rec();
    tcyc = 0;
    load_q.delete(); en_q.delete(); sel_q.delete(); kr_q.delete();
    rcon_q.delete(); hs_q.delete(); ct_q.delete();
    ov_first = -1;
    en_noack = 0;
    ack_noen = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ov(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  bus.in_ready,  1);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_key_req"},   bus.key_req,   0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_key_round"}, bus.key_round, 0);
    check({tag, "_rcon"},      bus.rcon,      8'h00);
    check({tag, "_dp_en"},     bus.dp_en,     0);
    check({tag, "_dp_sel"},    bus.dp_sel,    0);
    check({tag, "_dp_load"},   bus.dp_load,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // model pins against FIPS-197 values
    check("sbox_53", sbox(8'h53), 8'hed);
    check128("key_round1", key_step(KEY, 8'h01), 128'ha0fafe1788542cb123a339392a6c7605);

    step(3);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // zero-wait key source, in_valid pulse at cycle 5
    bus.out_ready = 1'b1;
    ack_mode = 1;
    step(1);
    clear_rec();
    step(5);
    bus.in_valid = 1'b1;
    step(1);
    bus.in_valid = 1'b0;
    step(20);
    check("t1_load_cnt", load_q.size(), 1);
    check("t1_load_cyc", qget(load_q, 0), 5);
    check("t1_en_cnt", en_q.size(), 11);
    check("t1_en_first", qget(en_q, 0), 6);
    check("t1_en_last", qget(en_q, 10), 16);
    check("t1_sel_first", qget(sel_q, 0), 0);
    check("t1_sel_last", qget(sel_q, 10), 2);
    n = 0;
    for (int i = 1; i <= 9; i++) if (qget(sel_q, i) == 1) n++;
    check("t1_sel_round_cnt", n, 9);
    check("t1_rcon_last", qget(rcon_q, 10), 8'h36);
    check("t1_ov_first", ov_first, 17);
    check("t1_ct_cnt", ct_q.size(), 1);
    if (ct_q.size() > 0) check128("t1_ciphertext", ct_q[0], CT);

    // key source acks every third KEY cycle
    ack_mode = 2;
    clear_rec();
    step(2);
    bus.in_valid = 1'b1;
    step(1);
    bus.in_valid = 1'b0;
    step(45);
    check("t2_en_cnt", en_q.size(), 11);
    check("t2_en_noack", en_noack, 0);
    check("t2_ack_noen", ack_noen, 0);
    n = 0;
    for (int i = 0; i <= NR; i++) if (qget(kr_q, i) != i) n++;
    check("t2_round_seq_err", n, 0);
    check("t2_en_last", qget(en_q, 10), 35);
    check("t2_ov_first", ov_first, 36);
    if (ct_q.size() > 0) check128("t2_ciphertext", ct_q[0], CT);
    else check("t2_ct_cnt", ct_q.size(), 1);

    // consumer stalls 20 cycles in DONE
    ack_mode = 1;
    bus.out_ready = 1'b0;
    clear_rec();
    bus.in_valid = 1'b1;
    step(1);
    bus.in_valid = 1'b0;
    wait_ov(30, ok);
    check("t3_reach_done", ok, 1);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      @(negedge clk);
      check("t3_hold_out_valid", bus.out_valid, 1);
      check("t3_hold_in_ready", bus.in_ready, 0);
      check("t3_hold_dp_load", bus.dp_load, 0);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step(1);
    @(negedge clk);
    check("t3_release_in_ready", bus.in_ready, 1);
    check("t3_release_busy", bus.busy, 0);
    check("t3_release_out_valid", bus.out_valid, 0);
    check("t3_load_cnt", load_q.size(), 1);
    @(posedge clk);
    #1;

    // two back-to-back blocks, in_valid held high
    clear_rec();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && load_q.size() < 2; i++) step(1);
    bus.in_valid = 1'b0;
    step(16);
    check("t4_load_cnt", load_q.size(), 2);
    check("t4_load_first", qget(load_q, 0), 0);
    check("t4_hs_first", qget(hs_q, 0), 12);
    check("t4_load_second", qget(load_q, 1), 13);
    check("t4_hs_second", qget(hs_q, 1), 25);
    check("t4_en_cnt", en_q.size(), 22);
    n = 0;
    for (int i = 0; i < 11; i++)
      if (qget(sel_q, i) != qget(sel_q, i + 11) || qget(en_q, i) + 13 != qget(en_q, i + 11)) n++;
    check("t4_run_diff", n, 0);
    if (ct_q.size() == 2) begin
      check128("t4_ct0", ct_q[0], CT);
      check128("t4_ct1", ct_q[1], CT);
    end else begin
      check("t4_ct_cnt", ct_q.size(), 2);
    end

    // reset while round 4 is applied
    clear_rec();
    bus.in_valid = 1'b1;
    step(1);
    bus.in_valid = 1'b0;
    step(4);
    check("t5_round_before_rst", bus.key_round, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    step(2);
    rst_n = 1'b1;
    step(1);
    clear_rec();
    bus.in_valid = 1'b1;
    step(1);
    bus.in_valid = 1'b0;
    step(20);
    check("t5_ov_first", ov_first, 12);
    check("t5_hs_cnt", hs_q.size(), 1);
    if (ct_q.size() > 0) check128("t5_ciphertext", ct_q[0], CT);

    // spurious key_ack in IDLE and DONE
    ack_mode = 3;
    bus.out_ready = 1'b0;
    clear_rec();
    step(5);
    check("t6_idle_en_cnt", en_q.size(), 0);
    check("t6_idle_key_round", bus.key_round, NR);
    bus.in_valid = 1'b1;
    step(1);
    bus.in_valid = 1'b0;
    wait_ov(30, ok);
    check("t6_reach_done", ok, 1);
    step(5);
    check("t6_done_en_cnt", en_q.size(), 11);
    check("t6_done_key_round", bus.key_round, NR);
    check("t6_done_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    step(2);
    check("t6_back_idle", bus.in_ready, 1);

    ack_mode = 0;
    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES-128 encryption sequencer that owns the round loop around the `addroundkey`/`shiftrows`/`subbytes`/`mixcolumns` state datapath. It:
- accepts a block over a valid/ready handshake;
- requests each round key from the key-expansion unit over a req/ack handshake;
- steers the datapath through the initial whitening, NR-1 full rounds and the final round (no MixColumns);
- presents the result over a valid/ready handshake.

It holds no 128-bit data itself: it only produces datapath controls, round index and round constant.

## Interface
Parameters:
- `NR`, 10, number of cipher rounds (10 for AES-128).
- `RW`, 4, width of round index; must satisfy 2^RW > NR.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  plaintext block present on datapath input.
- `in_ready`  output  1  controller can accept a block.
- `key_req`  output  1  request for round key `key_round`.
- `key_ack`  input  1  single-cycle pulse: round key valid on datapath `roundkey` bus this cycle.
- `key_round`  output  RW  round index of the requested/applied key, 0..NR.
- `rcon`  output  8  round constant for `key_round`, driven to the key expander.
- `dp_load`  output  1  capture input block into datapath input stage.
- `dp_sel`  output  2  datapath operation: 0 = whitening (state ^ key0), 1 = full round, 2 = final round (MixColumns bypassed), 3 = reserved.
- `dp_en`  output  1  state-register write enable.
- `out_valid`  output  1  ciphertext valid in state register.
- `out_ready`  input  1  consumer accepts ciphertext.
- `busy`  output  1  block in flight (KEY or DONE).

## Operation
- FSM has three states: IDLE, KEY, DONE.
- **IDLE**
  - `in_ready`=1.
  - `dp_load` = `in_valid & in_ready`, combinational.
  - On accept: `key_round`<=0, go to KEY.
- **KEY**
  - `key_req`=1.
  - Cycle with `key_ack`=1: `dp_en`=1, and `dp_sel` = 0 if `key_round`==0, 2 if `key_round`==NR, else 1.
  - After that ack: if `key_round`==NR, go to DONE; else `key_round`<=`key_round`+1 and stay in KEY.
  - Cycle with `key_ack`=0: `dp_en`=0 and state holds (wait states unbounded).
- **DONE**
  - `out_valid`=1, held until `out_ready`.
  - On `out_valid & out_ready`: go to IDLE.
- Signals outside their owning state:
  - `dp_en`, `dp_load` = 0 except as specified above.
  - `dp_sel` = 0 whenever `dp_en`=0.
  - `busy` = (state != IDLE).
- `rcon` is combinational from `key_round`:
  - `key_round` 0 gives 8'h00.
  - Rounds 1..10 give 01,02,04,08,10,20,40,80,1B,36.
  - Values > 10 give 8'h00.
- Boundary conditions:
  - `key_ack` outside KEY is ignored.
  - `in_valid` while busy is ignored: `in_ready`=0, no `dp_load`.
  - `out_ready` outside DONE is ignored.
  - `key_round` never exceeds NR and never wraps.
  - `rst_n` low at any time: immediately return to IDLE. The in-flight block is discarded with no partial `out_valid`.

## Timing
- Reset values:
  - state=IDLE, `key_round`=0.
  - `in_ready`=1, `rcon`=8'h00.
  - `key_req`, `dp_load`, `dp_en`, `dp_sel`, `out_valid`, `busy` = 0.
- All outputs are Moore from registered state/`key_round`. Exceptions:
  - `dp_load`, combinational from `in_valid`.
  - `dp_en`/`dp_sel`, combinational from `key_ack`.
- Zero-wait key source (ack high every KEY cycle):
  - accept at cycle T;
  - whitening at T+1;
  - rounds 1..NR at T+2..T+NR+1;
  - `out_valid` at T+NR+2.
- For NR=10: 12-cycle latency and a 13-cycle minimum occupancy per block, because the IDLE cycle is required.
- Back-to-back blocks: earliest next accept is the cycle after the output handshake.
- Each key wait cycle adds exactly one cycle of latency.

## Structure
- Shared package `aes_pkg` holds:
  - `dp_sel` encodings `SEL_WHITEN`/`SEL_ROUND`/`SEL_FINAL`;
  - FSM state encodings;
  - default `NR` and `RW`.
- One sub-module, `aes_rcon`: a combinational round-index to rcon lookup, reused by the key-expansion unit.

## Test plan
- **Zero-wait key source, NR=10**, `in_valid` pulse at cycle 5:
  - `dp_load` at 5;
  - `dp_en` at 6..16;
  - `dp_sel` 0 at 6, 1 at 7..15, 2 at 16;
  - `rcon` 8'h36 at 16;
  - `out_valid` at 17.
- **Key source acks every 3rd KEY cycle:**
  - exactly 11 `dp_en` pulses, each coincident with `key_ack`;
  - `key_round` sequence 0..10 with no skips;
  - `out_valid` after the 11th ack + 1.
- **`out_ready` held low 20 cycles in DONE:**
  - `out_valid` stays 1, `in_ready` stays 0;
  - `in_valid` pulses produce no `dp_load`;
  - release gives IDLE the next cycle.
- **Two back-to-back blocks with `out_ready`=1:**
  - second `dp_load` one cycle after the first output handshake;
  - second run is identical to the first.
- **`rst_n` low during round 4:**
  - all outputs at reset values asynchronously;
  - after release, a new block completes normally with no stale `out_valid`.
- **Spurious `key_ack` in IDLE and DONE:**
  - no `dp_en`, no `key_round` change.
- **End-to-end with a behavioural datapath model** using FIPS-197 key 2b7e1516 28aed2a6 abf71588 09cf4f3c and plaintext 3243f6a8 885a308d 313198a2 e0370734:
  - ciphertext 3925841d 02dc09fb dc118597 196a0b32.
